// File: rtl/ram_arb_pkg.sv
// Shared types for the DualRAM access arbiter.
// The FSM state encoding lives here so the top and any future siblings agree.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_CLEAR
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side bundle for the RAM access arbiter.
// Requesters drive the master modport, the arbiter sits on slave.
interface ram_arb_req_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 16
);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ*DATA_SIZE-1:0] req_wdata;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DATA_SIZE-1:0]         rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Search wraps cyclically; gnt is one-hot, gnt_any flags a hit.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(ptr) + k) % N;
      jj = IW'(j);
      if (!gnt_any && req[jj]) begin
        gnt_any = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin sharing of one DualRAM among NUM_REQ requesters.
// Zero-sweeps the whole RAM after reset and on clear_req.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int NUM_REQ   = 2
) (
  input  logic                 wclk,
  input  logic                 rst_n,
  input  logic                 clear_req,
  output logic                 busy,
  ram_arb_req_if.slave         bus,
  output logic                 ram_wclken,
  output logic [ADDR_SIZE-1:0] ram_waddr,
  output logic [DATA_SIZE-1:0] ram_wdata,
  output logic [ADDR_SIZE-1:0] ram_raddr,
  input  logic [DATA_SIZE-1:0] ram_rdata
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [ADDR_SIZE-1:0] LAST = '1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_REQ - 1);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [ADDR_SIZE-1:0] sweep_cnt;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        ptr_nxt;
  logic [IW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   rd_gnt;
  logic                 gnt_any;
  logic                 run_gnt;
  logic                 g_we;
  logic [ADDR_SIZE-1:0] g_addr;
  logic [DATA_SIZE-1:0] g_wdata;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign g_we    = bus.req_we[gnt_idx];
  assign g_addr  = bus.req_addr[int'(gnt_idx)*ADDR_SIZE +: ADDR_SIZE];
  assign g_wdata = bus.req_wdata[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE];
  assign ptr_nxt = (gnt_idx == IDX_MAX) ? '0 : gnt_idx + 1'b1;

  assign bus.req_ready = run_gnt ? gnt : '0;
  assign rd_gnt        = (run_gnt && !g_we) ? gnt : '0;

  // clear_req beats any pending request in the cycle it is seen
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    run_gnt    = 1'b0;
    ram_wclken = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    ram_raddr  = '0;
    unique case (state)
      ST_INIT, ST_CLEAR: begin
        busy       = 1'b1;
        ram_wclken = 1'b1;
        ram_waddr  = sweep_cnt;
        if (sweep_cnt == LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
        end else if (gnt_any) begin
          run_gnt = 1'b1;
          if (g_we) begin
            ram_wclken = 1'b1;
            ram_waddr  = g_addr;
            ram_wdata  = g_wdata;
          end else begin
            ram_raddr = g_addr;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      if (busy)    sweep_cnt <= sweep_cnt + 1'b1;
      if (run_gnt) rr_ptr    <= ptr_nxt;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= rd_gnt;
      if (|rd_gnt) bus.rsp_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter with a behavioural DualRAM.
// Directed accesses push expected read responses; a monitor pops them.
module tb_ram_access_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int NR    = 2;
  localparam int DEPTH = 256;

  typedef struct {
    int             idx;
    logic [DW-1:0]  data;
    int             cyc;
  } exp_t;

  logic          wclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear_req = 1'b0;
  logic          busy;
  logic          ram_wclken;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [DEPTH];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sbq[$];
  exp_t mon_e;

  ram_arb_req_if #(
    .NUM_REQ   (NR),
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW)
  ) bus ();

  ram_access_arbiter #(
    .DATA_SIZE (DW),
    .ADDR_SIZE (AW),
    .NUM_REQ   (NR)
  ) dut (
    .wclk       (wclk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .busy       (busy),
    .bus        (bus),
    .ram_wclken (ram_wclken),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata)
  );

  always #5 wclk = ~wclk;

  always @(posedge wclk) cyc <= cyc + 1;

  always @(posedge wclk) if (ram_wclken) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge wclk) begin
    if (rst_n && bus.rsp_valid != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.rsp_valid[i]) begin
          vectors++;
          if (sbq.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: req %0d data %0h, none expected",
                     i, bus.rsp_rdata);
          end else begin
            mon_e = sbq.pop_front();
            if (i != mon_e.idx || bus.rsp_rdata !== mon_e.data ||
                cyc != mon_e.cyc) begin
              miscompares++;
              $display("FAIL rsp: got req %0d data %0h cyc %0d expected req %0d data %0h cyc %0d",
                       i, bus.rsp_rdata, cyc, mon_e.idx, mon_e.data, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  task automatic sync();
    @(posedge wclk);
    #1;
  endtask

  task automatic push_exp(input int r, input logic [DW-1:0] d);
    exp_t e;
    e.idx  = r;
    e.data = d;
    e.cyc  = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_busy"},  busy, 1);
    chk({nm, "_ready"}, bus.req_ready, 0);
    chk({nm, "_rspv"},  bus.rsp_valid, 0);
    chk({nm, "_rspd"},  bus.rsp_rdata, 0);
    chk({nm, "_waddr"}, ram_waddr, 0);
  endtask

  task automatic check_sweep(input string nm);
    int n;
    int bad;
    int nz;
    n   = 0;
    bad = 0;
    nz  = 0;
    forever begin
      @(negedge wclk);
      if (!busy || n > 300) break;
      if (ram_waddr != AW'(n) || !ram_wclken || ram_wdata != '0 ||
          bus.req_ready != '0) bad++;
      n++;
    end
    chk({nm, "_len"}, n, 256);
    chk({nm, "_wr"},  bad, 0);
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
    chk({nm, "_zero"}, nz, 0);
  endtask

  task automatic access(input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                        input int max_wait, input string nm);
    int w;
    w = 0;
    bus.req_valid[r]            = 1'b1;
    bus.req_we[r]               = we;
    bus.req_addr[r*AW +: AW]    = a;
    bus.req_wdata[r*DW +: DW]   = d;
    forever begin
      @(negedge wclk);
      if (bus.req_ready[r] || w > 600) break;
      w++;
    end
    chk({nm, "_wait"}, w, max_wait);
    if (bus.req_ready[r]) begin
      if (we) begin
        chk({nm, "_wport"}, {ram_wclken, ram_waddr, ram_wdata}, {1'b1, a, d});
      end else begin
        chk({nm, "_rport"}, {ram_wclken, ram_raddr}, {1'b0, a});
        push_exp(r, exp_rd);
      end
    end
    sync();
    bus.req_valid[r] = 1'b0;
  endtask

  initial begin
    int n;
    logic [NR-1:0] exp_g;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;
    #2 rst_n = 1'b0;
    sync();
    sync();
    check_reset("rst");
    rst_n = 1'b1;

    check_sweep("init");
    sync();
    access(0, 1'b0, 8'h7F, 16'h0, 16'h0000, 0, "t1_rd");

    access(0, 1'b1, 8'hA5, 16'h1234, 16'h0, 0, "t2_wr");
    access(0, 1'b0, 8'hA5, 16'h0, 16'h1234, 0, "t2_rd");
    @(negedge wclk);
    chk("idle_ram", {ram_wclken, ram_waddr, ram_wdata, ram_raddr}, 0);
    chk("idle_ready", bus.req_ready, 0);
    sync();

    access(1, 1'b1, 8'h10, 16'hBEEF, 16'h0, 0, "t4_wr");
    access(0, 1'b0, 8'h10, 16'h0, 16'hBEEF, 0, "t4_rd");
    access(1, 1'b0, 8'hA5, 16'h0, 16'h1234, 0, "r1_rd");

    bus.req_we             = '0;
    bus.req_addr[0 +: AW]  = 8'h10;
    bus.req_addr[AW +: AW] = 8'hA5;
    bus.req_valid          = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge wclk);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_gnt%0d", k), bus.req_ready, exp_g);
      if (bus.req_ready[0]) push_exp(0, 16'hBEEF);
      if (bus.req_ready[1]) push_exp(1, 16'h1234);
    end
    sync();
    bus.req_valid = '0;

    access(0, 1'b1, 8'h55, 16'hFFFF, 16'h0, 0, "t5_wr");
    bus.req_we[0]         = 1'b0;
    bus.req_addr[0 +: AW] = 8'h55;
    bus.req_valid[0]      = 1'b1;
    clear_req             = 1'b1;
    @(negedge wclk);
    chk("t5_nogrant", bus.req_ready, 0);
    sync();
    clear_req = 1'b0;
    check_sweep("clear");
    chk("t5_gnt", bus.req_ready, 2'b01);
    if (bus.req_ready[0]) push_exp(0, 16'h0000);
    sync();
    bus.req_valid = '0;

    access(1, 1'b1, 8'h33, 16'h5A5A, 16'h0, 0, "t6_wr");
    access(1, 1'b0, 8'h33, 16'h0, 16'h5A5A, 0, "t6_rd");
    sync();
    clear_req = 1'b1;
    sync();
    clear_req = 1'b0;
    n = 0;
    forever begin
      @(negedge wclk);
      if ((busy && ram_waddr == 8'd100) || n > 400) break;
      n++;
    end
    chk("t6_reach100", n, 100);
    rst_n = 1'b0;
    #1;
    check_reset("t6_rst");
    sync();
    rst_n = 1'b1;
    check_sweep("t6_sweep");

    sync();
    sync();
    chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
